lfsr_burst_arb: RTL

//  Shares one 8-bit lfsr instance between N_REQ clients. Round-robin grants one client at a time.

---
 rtl/lfsr_burst_arb_pkg.sv | 18 +
 rtl/lfsr_burst_arb_rr_arbiter.sv | 32 +++
 rtl/lfsr_burst_arb.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/lfsr_burst_arb_pkg.sv
// rtl/lfsr_burst_arb_pkg.sv - shared FSM encoding, defaults and helpers for the LFSR burst arbiter
package lfsr_burst_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      SETTLE = 2'd2,
      STREAM = 2'd3
   } state_t;

   localparam int         WIDTH_C        = 8;
   localparam logic [7:0] DEFAULT_SEED_C = 8'hD3;

   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/lfsr_burst_arb_rr_arbiter.sv
// rtl/lfsr_burst_arb_rr_arbiter.sv - combinational round-robin pick: first requester at or after ptr
module lfsr_burst_arb_rr_arbiter
   import lfsr_burst_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   always_comb begin : pick
      int c;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      c   = 0;
      for (int i = 0; i < N; i++) begin
         c = int'(ptr) + i;
         if (c >= N) c = c - N;
         if (!any && req[c]) begin
            any    = 1'b1;
            gnt[c] = 1'b1;
            idx    = IW'(c);
         end
      end
   end

endmodule

// File: rtl/lfsr_burst_arb.sv
// rtl/lfsr_burst_arb.sv - shares one LFSR among clients, streaming round-robin bursts of random bytes
module lfsr_burst_arb
   import lfsr_burst_arb_pkg::*;
#(
   parameter int               N_REQ        = 4,
   parameter int               WIDTH        = WIDTH_C,
   parameter int               LEN_W        = 4,
   parameter logic [WIDTH-1:0] DEFAULT_SEED = DEFAULT_SEED_C
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ-1:0]       req_reseed,
   input  logic [N_REQ*WIDTH-1:0] seed_in,
   input  logic [N_REQ*LEN_W-1:0] len_in,
   output logic [N_REQ-1:0]       gnt,
   output logic [WIDTH-1:0]       out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_last,
   output logic [WIDTH-1:0]       lfsr_seed,
   output logic                   lfsr_load,
   input  logic [WIDTH-1:0]       lfsr_data,
   output logic                   lockup,
   output logic                   busy
);

   localparam int IW = $clog2(N_REQ);

   state_t           state, state_d;
   logic [IW-1:0]    ptr, ptr_d, win_idx, win_d, arb_idx;
   logic [N_REQ-1:0] arb_gnt, gnt_d;
   logic             arb_any;
   logic [LEN_W:0]   len_q, len_d, issued, issued_d;
   logic [WIDTH-1:0] data_d, lseed_d, sel_seed;
   logic [LEN_W-1:0] sel_len;
   logic             sel_reseed;
   logic             valid_d, last_d, load_d, lockup_d;
   logic             hs, capture_ok;

   lfsr_burst_arb_rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
      .req (req),
      .ptr (ptr),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   always_comb begin
      sel_seed   = '0;
      sel_len    = '0;
      sel_reseed = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (arb_gnt[i]) begin
            sel_seed   = seed_in[i*WIDTH +: WIDTH];
            sel_len    = len_in[i*LEN_W +: LEN_W];
            sel_reseed = req_reseed[i];
         end
      end
   end

   assign hs         = out_valid & out_ready;
   assign capture_ok = (!out_valid || out_ready) && (issued < len_q);
   assign busy       = (state != IDLE);

   always_comb begin
      state_d  = state;
      gnt_d    = gnt;
      ptr_d    = ptr;
      win_d    = win_idx;
      len_d    = len_q;
      issued_d = issued;
      data_d   = out_data;
      valid_d  = out_valid;
      last_d   = out_last;
      load_d   = 1'b0;
      lseed_d  = lfsr_seed;
      lockup_d = 1'b0;
      case (state)
         IDLE: begin
            if (arb_any) begin
               gnt_d    = arb_gnt;
               win_d    = arb_idx;
               issued_d = '0;
               len_d    = (sel_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, sel_len};
               if (sel_reseed) begin
                  load_d  = 1'b1;
                  lseed_d = sel_seed;
                  state_d = LOAD;
               end else begin
                  state_d = STREAM;
               end
            end
         end
         LOAD: state_d = SETTLE;
         SETTLE: begin
            if (hs) valid_d = 1'b0;
            state_d = STREAM;
         end
         STREAM: begin
            if (hs && out_last) begin
               gnt_d   = '0;
               valid_d = 1'b0;
               last_d  = 1'b0;
               ptr_d   = IW'(wrap_inc(int'(win_idx), N_REQ));
               state_d = IDLE;
            end else if (capture_ok) begin
               // A zero from the LFSR would stick forever; reseed instead of emitting it.
               if (lfsr_data == '0) begin
                  load_d   = 1'b1;
                  lseed_d  = DEFAULT_SEED;
                  lockup_d = 1'b1;
                  state_d  = SETTLE;
                  if (hs) valid_d = 1'b0;
               end else begin
                  data_d   = lfsr_data;
                  valid_d  = 1'b1;
                  issued_d = issued + 1'b1;
                  last_d   = (issued == len_q - 1'b1);
               end
            end else if (hs) begin
               valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         gnt       <= '0;
         ptr       <= '0;
         win_idx   <= '0;
         len_q     <= '0;
         issued    <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         lfsr_load <= 1'b0;
         lfsr_seed <= '0;
         lockup    <= 1'b0;
      end else begin
         state     <= state_d;
         gnt       <= gnt_d;
         ptr       <= ptr_d;
         win_idx   <= win_d;
         len_q     <= len_d;
         issued    <= issued_d;
         out_data  <= data_d;
         out_valid <= valid_d;
         out_last  <= last_d;
         lfsr_load <= load_d;
         lfsr_seed <= lseed_d;
         lockup    <= lockup_d;
      end
   end

endmodule
